// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-file geometry and address type.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, hardwired-zero $0 and synchronous clear.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  reg_addr_t        waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  reg_addr_t        raddr_a_i,
  input  reg_addr_t        raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  // Clear wins over a write; entry 0 is forced to zero so it never holds data.
  always_comb begin
    regs_d = regs_q;
    if (clr_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (we_i && (waddr_i != ZERO_REG)) begin
      regs_d[waddr_i] = wdata_i;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    regs_q <= regs_d;
  end

  always_comb begin
    if (raddr_a_i == ZERO_REG) begin
      rdata_a_o = '0;
    end else begin
      rdata_a_o = regs_q[raddr_a_i];
    end
    if (raddr_b_i == ZERO_REG) begin
      rdata_b_o = '0;
    end else begin
      rdata_b_o = regs_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// MIPS writeback stage: result select, register-file commit and commit counter.
// Define WB_BYPASS_EN for write-first reads of the register being committed.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     alu_out_iwb32,
  input  logic [WIDTH-1:0]     read_data_iwb32,
  input  reg_addr_t            dst_reg_addr_iwb5,
  input  logic                 enable_wreg_iwb,
  input  logic                 mem_to_reg_iwb,
  input  reg_addr_t            rs_addr_id5,
  input  reg_addr_t            rt_addr_id5,
  output logic [WIDTH-1:0]     rs_data_od32,
  output logic [WIDTH-1:0]     rt_data_od32,
  output logic [WIDTH-1:0]     result_owb32,
  output logic [CNT_WIDTH-1:0] wb_count_o
);

  logic                 commit_s;
  logic [WIDTH-1:0]     rf_rs_data_s;
  logic [WIDTH-1:0]     rf_rt_data_s;
  logic [CNT_WIDTH-1:0] wb_count_d;
  logic [CNT_WIDTH-1:0] wb_count_q;

  always_comb begin
    if (mem_to_reg_iwb) begin
      result_owb32 = read_data_iwb32;
    end else begin
      result_owb32 = alu_out_iwb32;
    end
  end

  assign commit_s = enable_wreg_iwb && (dst_reg_addr_iwb5 != ZERO_REG);

  regfile_2r1w #(
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk_i     (clk_i),
    .clr_i     (reset_i),
    .we_i      (commit_s),
    .waddr_i   (dst_reg_addr_iwb5),
    .wdata_i   (result_owb32),
    .raddr_a_i (rs_addr_id5),
    .raddr_b_i (rt_addr_id5),
    .rdata_a_o (rf_rs_data_s),
    .rdata_b_o (rf_rt_data_s)
  );

`ifdef WB_BYPASS_EN
  // A write that reset is about to discard must not be bypassed either.
  always_comb begin
    if (!reset_i && commit_s && (rs_addr_id5 == dst_reg_addr_iwb5)) begin
      rs_data_od32 = result_owb32;
    end else begin
      rs_data_od32 = rf_rs_data_s;
    end
    if (!reset_i && commit_s && (rt_addr_id5 == dst_reg_addr_iwb5)) begin
      rt_data_od32 = result_owb32;
    end else begin
      rt_data_od32 = rf_rt_data_s;
    end
  end
`else
  always_comb begin
    rs_data_od32 = rf_rs_data_s;
    rt_data_od32 = rf_rt_data_s;
  end
`endif

  always_comb begin
    if (reset_i) begin
      wb_count_d = '0;
    end else if (commit_s) begin
      wb_count_d = wb_count_q + CNT_WIDTH'(1);
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    wb_count_q <= wb_count_d;
  end

  assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed plan items plus random traffic
// checked against an array-based architectural model.
module tb_wb_regfile;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          en = 1'b0;
  logic          mtr = 1'b0;
  logic [4:0]    dst = 5'd0;
  logic [4:0]    rs = 5'd0;
  logic [4:0]    rt = 5'd0;
  logic [W-1:0]  alu = 32'd0;
  logic [W-1:0]  rd = 32'd0;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  rt_data;
  logic [W-1:0]  result;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  wb_regfile #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .alu_out_iwb32     (alu),
    .read_data_iwb32   (rd),
    .dst_reg_addr_iwb5 (dst),
    .enable_wreg_iwb   (en),
    .mem_to_reg_iwb    (mtr),
    .rs_addr_id5       (rs),
    .rt_addr_id5       (rt),
    .rs_data_od32      (rs_data),
    .rt_data_od32      (rt_data),
    .result_owb32      (result),
    .wb_count_o        (count)
  );

  typedef struct packed {
    logic [W-1:0]  rs;
    logic [W-1:0]  rt;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int unsigned mcount = 0;
  bit          mdl_valid = 1'b0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural read: $0 is zero, optional write-first bypass, else stored value.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [31:0] res,
                                           input bit commit, input logic [4:0] wa);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (commit && a == wa) return res;
`endif
    return mdl[a];
  endfunction

  task automatic step(input bit r, input bit e, input bit m, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] l,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] res;
    bit          commit;
    exp_t        x;
    reset_i = r; en = e; mtr = m; dst = d; alu = a; rd = l; rs = ra; rt = rb;
    res    = m ? l : a;
    commit = e && (d != 5'd0) && !r;
    if (mdl_valid) begin
      x.rs  = ref_read(ra, res, commit, d);
      x.rt  = ref_read(rb, res, commit, d);
      x.res = res;
      x.cnt = CW'(mcount);
      sb.push_back(x);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mcount    = 0;
      mdl_valid = 1'b1;
    end else if (commit) begin
      mdl[d] = res;
      mcount = (mcount + 1) % (1 << CW);
    end
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rs_data", rs_data, e.rs);
      chk("rt_data", rt_data, e.rt);
      chk("result", result, e.res);
      chk("wb_count", 32'(count), 32'(e.cnt));
    end
  end

  always @(posedge clk) begin
    if ($isunknown(en)) begin
      total++;
      $display("FAIL enable_x: enable_wreg_iwb is %b, expected a known value", en);
    end
  end

  initial begin
    #1;
    // 1: reset, then sweep every address on both ports
    step(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
    // 2: ALU commit then load commit, read both back
    step(0, 1, 0, 5'd5, 32'h0000_1234, 32'h0BAD_0BAD, 5'd0, 5'd0);
    step(0, 1, 1, 5'd6, 32'h1111_1111, 32'hDEAD_BEEF, 5'd5, 5'd6);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd6);
    // 3: write to $0 is dropped and not counted
    step(0, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    // 4: same-cycle read of the register being written
    step(0, 1, 0, 5'd9, 32'h0000_0011, 32'd0, 5'd0, 5'd0);
    step(0, 1, 0, 5'd9, 32'hA5A5_A5A5, 32'd0, 5'd9, 5'd9);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
    // 5: reset beats a simultaneous commit; next commit counts as 1
    step(0, 1, 0, 5'd3, 32'h0000_0055, 32'd0, 5'd3, 5'd0);
    step(1, 1, 0, 5'd3, 32'h0000_0077, 32'd0, 5'd3, 5'd0);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);
    step(0, 1, 0, 5'd4, 32'h0000_0042, 32'd0, 5'd3, 5'd4);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd4);
    // 6: 17 commits wrap a 4-bit counter to 1
    step(1, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 17; i++) step(0, 1, i[0], 5'd1, 32'h100 + 32'(i), 32'h200 + 32'(i), 5'd1, 5'd2);
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd1);
    // Random traffic with a small destination set to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d, a, b;
      d = 5'($urandom_range(0, 7));
      a = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 7));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           d, $urandom, $urandom, a, b);
    end
    step(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
